// File: rtl/osc_meter_pkg.sv
// Shared types and defaults for the oscillator frequency meter.
package osc_meter_pkg;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    IDLE   = 2'd1,
    GATE   = 2'd2,
    DONE   = 2'd3
  } meter_state_t;

  // 1 s gate at a 2.08 MHz system clock
  localparam int GATE_CYCLES_DEF = 2080000;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Input synchronizer plus registered rising-edge detector.
// A sig rise reaches `rise` SYNC_STAGES+1 cycles later as a one-cycle pulse.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;

  // sync chain shifts toward the MSB; prev and rise are registered behind it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d_async};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
    end
  end

  assign rise = r_rise;

endmodule

// File: rtl/osc_freq_meter.sv
// Gated edge counter: counts sig_in rising edges over GATE_CYCLES clk cycles.
module osc_freq_meter
  import osc_meter_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             continuous,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  localparam int TMR_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int WU_W  = $clog2(SYNC_STAGES + 2);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);
  localparam logic [WU_W-1:0]  WU_LAST  = WU_W'(SYNC_STAGES);

  meter_state_t     r_state, w_state_nxt;
  logic [WU_W-1:0]  r_wu;
  logic [TMR_W-1:0] r_timer;
  logic [CNT_W-1:0] r_ecnt, w_ecnt_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic [CNT_W-1:0] r_count;
  logic             r_valid;
  logic             r_overflow;
  logic             w_rise;
  logic             w_clr;
  logic             w_last;
  logic             w_inc;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_async (sig_in),
    .rise    (w_rise)
  );

  // Saturating edge count including this cycle's pulse; the last gate cycle's
  // edge is folded in here so the latched result can appear during DONE.
  always_comb begin
    w_inc      = w_rise && (r_state == GATE);
    w_ecnt_nxt = r_ecnt;
    if (w_inc && !(&r_ecnt)) w_ecnt_nxt = r_ecnt + CNT_W'(1);
    w_ovf_nxt  = r_ovf | (w_inc & (&w_ecnt_nxt));
  end

  // Next-state logic; clr restarts a gate, last marks the final gate cycle
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      WARMUP: if (r_wu == WU_LAST) w_state_nxt = IDLE;
      IDLE: begin
        if (start || continuous) begin
          w_state_nxt = GATE;
          w_clr       = 1'b1;
        end
      end
      GATE: begin
        if (r_timer == TMR_LAST) begin
          w_state_nxt = DONE;
          w_last      = 1'b1;
        end
      end
      DONE: begin
        if (continuous) begin
          w_state_nxt = GATE;
          w_clr       = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = WARMUP;
    endcase
  end

  // State, warm-up counter, gate timer and edge counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WARMUP;
      r_wu    <= '0;
      r_timer <= '0;
      r_ecnt  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == WARMUP) r_wu <= r_wu + WU_W'(1);
      if (w_clr) begin
        r_timer <= '0;
        r_ecnt  <= '0;
        r_ovf   <= 1'b0;
      end else if (r_state == GATE) begin
        r_timer <= r_timer + TMR_W'(1);
        r_ecnt  <= w_ecnt_nxt;
        r_ovf   <= w_ovf_nxt;
      end
    end
  end

  // Result registers load on the last gate cycle so they are visible in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_valid <= w_last;
      if (w_last) begin
        r_count    <= w_ecnt_nxt;
        r_overflow <= w_ovf_nxt;
      end
    end
  end

  assign count    = r_count;
  assign valid    = r_valid;
  assign overflow = r_overflow;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_osc_freq_meter.sv
// Directed bench for osc_freq_meter, GATE_CYCLES=100 with CNT_W=8 and CNT_W=4
// instances driven from the same stimulus.
module tb_osc_freq_meter;

  localparam int G = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sig_in = 1'b0;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic [7:0] count;
  logic       valid, overflow, busy;
  logic [3:0] count4;
  logic       valid4, overflow4, busy4;

  int nchk = 0;
  int nerr = 0;
  int per  = 0;  // 0: sig_in held by the test, else square-wave period
  int ph   = 0;

  always #5 clk = ~clk;

  osc_freq_meter #(.GATE_CYCLES(G), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start),
    .continuous(continuous), .count(count), .valid(valid),
    .overflow(overflow), .busy(busy)
  );

  osc_freq_meter #(.GATE_CYCLES(G), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start),
    .continuous(continuous), .count(count4), .valid(valid4),
    .overflow(overflow4), .busy(busy4)
  );

  // advance one cycle; inputs change and outputs are observed 1 ns after the edge
  task automatic step();
    @(posedge clk); #1;
    if (per > 0) begin
      ph = (ph + 1) % per;
      sig_in = (ph < per / 2);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_period(input int p);
    per = p; ph = 0;
    if (p > 0) sig_in = 1'b1;
  endtask

  // steps until valid is seen or max cycles elapse
  task automatic wait_valid(input int max, output int n, output bit got);
    got = 1'b0; n = 0;
    while (!got && n < max) begin
      step(); n++;
      if (valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic test_reset();
    #1;
    nchk++; if (count !== 8'd0) begin nerr++; $display("FAIL rst_count got %0d want 0", count); end
    nchk++; if (valid !== 1'b0) begin nerr++; $display("FAIL rst_valid got %b want 0", valid); end
    nchk++; if (overflow !== 1'b0) begin nerr++; $display("FAIL rst_ovf got %b want 0", overflow); end
    nchk++; if (busy !== 1'b1) begin nerr++; $display("FAIL rst_busy got %b want 1", busy); end
    steps(2);
    rst_n = 1'b1;
    steps(2);
    nchk++; if (busy !== 1'b1) begin nerr++; $display("FAIL warmup_busy got %b want 1", busy); end
    step();
    nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL warmup_end got %b want 0", busy); end
  endtask

  task automatic test_basic();
    int n; bit got;
    set_period(10); steps(30);
    start = 1'b1; step(); start = 1'b0;
    wait_valid(150, n, got);
    nchk++; if (!got || n + 1 != 101) begin nerr++; $display("FAIL basic_latency got %0d (seen %b) want 101", n + 1, got); end
    nchk++; if (count !== 8'd10) begin nerr++; $display("FAIL basic_count got %0d want 10", count); end
    nchk++; if (overflow !== 1'b0) begin nerr++; $display("FAIL basic_ovf got %b want 0", overflow); end
    nchk++; if (busy !== 1'b1) begin nerr++; $display("FAIL basic_busy_done got %b want 1", busy); end
    step();
    nchk++; if (valid !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL basic_after valid %b busy %b want 0 0", valid, busy); end
  endtask

  task automatic test_saturation();
    int n; bit got;
    set_period(4); steps(20);
    start = 1'b1; step(); start = 1'b0;
    wait_valid(150, n, got);
    nchk++; if (!got || valid4 !== 1'b1) begin nerr++; $display("FAIL sat_valid got %b/%b want 1", got, valid4); end
    nchk++; if (count4 !== 4'd15 || overflow4 !== 1'b1) begin nerr++; $display("FAIL sat_count4 got %0d ovf %b want 15 ovf 1", count4, overflow4); end
    nchk++; if (count !== 8'd25 || overflow !== 1'b0) begin nerr++; $display("FAIL sat_count8 got %0d ovf %b want 25 ovf 0", count, overflow); end
    set_period(20); steps(45);
    start = 1'b1; step(); start = 1'b0;
    wait_valid(150, n, got);
    nchk++; if (!got || count4 !== 4'd5 || overflow4 !== 1'b0) begin nerr++; $display("FAIL sat_recover got %0d ovf %b want 5 ovf 0", count4, overflow4); end
  endtask

  task automatic test_continuous();
    int n; bit got;
    set_period(5); steps(20);
    continuous = 1'b1; step();
    wait_valid(150, n, got);
    nchk++; if (!got || n != 100) begin nerr++; $display("FAIL cont_first got %0d (seen %b) want 100", n, got); end
    nchk++; if (count !== 8'd20) begin nerr++; $display("FAIL cont_count1 got %0d want 20", count); end
    wait_valid(150, n, got);
    nchk++; if (!got || n != 101 || count !== 8'd20) begin nerr++; $display("FAIL cont_second gap %0d count %0d want 101 20", n, count); end
    wait_valid(150, n, got);
    continuous = 1'b0;
    nchk++; if (!got || n != 101 || count !== 8'd20) begin nerr++; $display("FAIL cont_third gap %0d count %0d want 101 20", n, count); end
    step();
    nchk++; if (busy !== 1'b0 || valid !== 1'b0) begin nerr++; $display("FAIL cont_stop busy %b valid %b want 0 0", busy, valid); end
  endtask

  task automatic test_start_busy();
    int n; bit got; int extra;
    set_period(10); steps(20);
    start = 1'b1; step(); start = 1'b0;
    steps(49);
    start = 1'b1; step(); start = 1'b0;
    wait_valid(150, n, got);
    nchk++; if (!got || n + 51 != 101) begin nerr++; $display("FAIL busy_latency got %0d (seen %b) want 101", n + 51, got); end
    nchk++; if (count !== 8'd10) begin nerr++; $display("FAIL busy_count got %0d want 10", count); end
    extra = 0;
    for (int i = 0; i < 150; i++) begin step(); if (valid === 1'b1) extra++; end
    nchk++; if (extra != 0 || busy !== 1'b0) begin nerr++; $display("FAIL busy_no_requeue extra %0d busy %b want 0 0", extra, busy); end
  endtask

  task automatic test_reset_midgate();
    int n; bit got;
    set_period(10); steps(20);
    start = 1'b1; step(); start = 1'b0;
    steps(40);
    set_period(0); sig_in = 1'b1;
    rst_n = 1'b0; #1;
    nchk++; if (count !== 8'd0 || valid !== 1'b0 || overflow !== 1'b0 || busy !== 1'b1) begin
      nerr++; $display("FAIL midrst_outputs count %0d valid %b ovf %b busy %b want 0 0 0 1", count, valid, overflow, busy);
    end
    steps(3);
    rst_n = 1'b1;
    steps(3);
    nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL midrst_warmup busy %b want 0", busy); end
    start = 1'b1; step(); start = 1'b0;
    wait_valid(150, n, got);
    nchk++; if (!got || count !== 8'd0) begin nerr++; $display("FAIL midrst_spurious count %0d (seen %b) want 0", count, got); end
  endtask

  // one-cycle sig_in pulses set at cycles ra, rb relative to the start cycle
  task automatic run_pair(input int ra, input int rb, input logic [7:0] exp, input string nm);
    set_period(0); sig_in = 1'b0; steps(10);
    for (int k = -5; k <= G; k++) begin
      start  = (k == 0);
      sig_in = (k == ra || k == rb);
      step();
    end
    start = 1'b0; sig_in = 1'b0;
    nchk++; if (valid !== 1'b1 || count !== exp) begin
      nerr++; $display("FAIL %s valid %b count %0d want 1 %0d", nm, valid, count, exp);
    end
    steps(3);
  endtask

  task automatic test_boundary();
    // edge pulses on first and last gate cycles: both counted
    run_pair(-2, G - 3, 8'd2, "bound_inside");
    // edge pulses in the start cycle (IDLE) and in DONE: neither counted
    run_pair(-3, G - 2, 8'd0, "bound_outside");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_continuous();
    test_start_busy();
    test_reset_midgate();
    test_boundary();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
